bitflip_accum: RTL and testbench

Readback error accumulator. It sits between the read-data capture path and the host-visible result registers. Each beat of DRAM read data is XOR-ed against the expected pattern, and the mismatch vector is split into 4-bit groups. Each group goes to a `pop_count4` instance, and the group counts are summed in a pipelined adder. The block emits a per-beat flip count stream and maintains saturating session totals: total flipped bits, beats seen, and beats with at least one flip.

---
 rtl/bitflip_accum_if.sv | 30 +++
 rtl/bitflip_accum.sv | 132 +++++++++++++
 tb/tb_bitflip_accum.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitflip_accum_if.sv
// Handshake and result bus for bitflip_accum: beat input, per-beat flip count and session totals.
interface bitflip_accum_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32,
  parameter int SUM_W  = $clog2(DATA_W + 1)
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] exp_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_flips;
  logic [CNT_W-1:0]  total_flips;
  logic [CNT_W-1:0]  total_beats;
  logic [CNT_W-1:0]  err_beats;
  logic              sat;
  logic [SUM_W-1:0]  max_flips;

  modport slave (
    input  clear, in_valid, rd_data, exp_data, out_ready,
    output in_ready, out_valid, out_flips, total_flips, total_beats, err_beats, sat, max_flips
  );

  modport master (
    output clear, in_valid, rd_data, exp_data, out_ready,
    input  in_ready, out_valid, out_flips, total_flips, total_beats, err_beats, sat, max_flips
  );
endinterface

// File: rtl/bitflip_accum.sv
// Readback error accumulator: two-stage popcount of rd_data^exp_data with saturating session totals.
// Define BITFLIP_ACCUM_MAX_EN to build the max_flips tracker; otherwise max_flips reads 0.
module pop_count4 (
  input  logic [3:0] i_nib,
  output logic [2:0] o_cnt
);
  assign o_cnt = 3'(i_nib[0]) + 3'(i_nib[1]) + 3'(i_nib[2]) + 3'(i_nib[3]);
endmodule

module bitflip_accum #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32,
  parameter int SUM_W  = $clog2(DATA_W + 1)
) (
  input  logic clk,
  input  logic rst_n,
  bitflip_accum_if.slave bus
);
  localparam int NIB = DATA_W / 4;
  localparam int CW1 = CNT_W + 1;

  logic [DATA_W-1:0]   w_mismatch;
  logic [NIB-1:0][2:0] w_nib_cnt;
  logic [NIB-1:0][2:0] r_nib_cnt;
  logic                r_s1_valid;
  logic                r_s2_valid;
  logic [SUM_W-1:0]    r_s2_sum;
  logic [SUM_W-1:0]    w_sum;
  logic                w_stall;
  logic                w_accept;
  logic                w_s2_load;
  logic [CNT_W-1:0]    r_total_flips;
  logic [CNT_W-1:0]    r_total_beats;
  logic [CNT_W-1:0]    r_err_beats;
  logic                r_sat;
  logic [CW1-1:0]      w_flips_next;
  logic [CW1-1:0]      w_beats_next;
  logic [CW1-1:0]      w_err_next;

  assign w_stall     = r_s2_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall && !bus.clear;
  assign w_accept    = bus.in_valid && bus.in_ready;
  // clear wins over a result arriving in S2 in the same cycle, so that beat is dropped
  assign w_s2_load   = !w_stall && r_s1_valid && !bus.clear;
  assign w_mismatch  = bus.rd_data ^ bus.exp_data;

  for (genvar g = 0; g < NIB; g++) begin : g_pop
    pop_count4 u_pop (
      .i_nib (w_mismatch[4*g +: 4]),
      .o_cnt (w_nib_cnt[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NIB; i++) begin
      w_sum = w_sum + SUM_W'(r_nib_cnt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_nib_cnt  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
    end else if (bus.clear) begin
      r_s1_valid <= 1'b0;
      r_nib_cnt  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_nib_cnt <= w_nib_cnt;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum <= w_sum;
      end
    end
  end

  // The extra top bit of each next value flags an add that would pass the clamp limit
  assign w_flips_next = {1'b0, r_total_flips} + CW1'(w_sum);
  assign w_beats_next = {1'b0, r_total_beats} + CW1'(1);
  assign w_err_next   = {1'b0, r_err_beats} + CW1'(w_sum != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total_flips <= '0;
      r_total_beats <= '0;
      r_err_beats   <= '0;
      r_sat         <= 1'b0;
    end else if (bus.clear) begin
      r_total_flips <= '0;
      r_total_beats <= '0;
      r_err_beats   <= '0;
      r_sat         <= 1'b0;
    end else if (w_s2_load) begin
      r_total_flips <= w_flips_next[CNT_W] ? '1 : w_flips_next[CNT_W-1:0];
      r_total_beats <= w_beats_next[CNT_W] ? '1 : w_beats_next[CNT_W-1:0];
      r_err_beats   <= w_err_next[CNT_W]   ? '1 : w_err_next[CNT_W-1:0];
      r_sat         <= r_sat | w_flips_next[CNT_W] | w_beats_next[CNT_W] | w_err_next[CNT_W];
    end
  end

`ifdef BITFLIP_ACCUM_MAX_EN
  logic [SUM_W-1:0] r_max_flips;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_flips <= '0;
    end else if (bus.clear) begin
      r_max_flips <= '0;
    end else if (w_s2_load && (w_sum > r_max_flips)) begin
      r_max_flips <= w_sum;
    end
  end

  assign bus.max_flips = r_max_flips;
`else
  assign bus.max_flips = '0;
`endif

  assign bus.out_valid   = r_s2_valid;
  assign bus.out_flips   = r_s2_sum;
  assign bus.total_flips = r_total_flips;
  assign bus.total_beats = r_total_beats;
  assign bus.err_beats   = r_err_beats;
  assign bus.sat         = r_sat;
endmodule

// File: tb/tb_bitflip_accum.sv
// Directed bench for bitflip_accum: one 32-bit-total instance and one 8-bit-total instance share stimulus.
module tb_bitflip_accum;
  localparam logic [63:0] PAT  = 64'hA5A5_3C3C_0FF0_9669;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef BITFLIP_ACCUM_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] rd_data;
  logic [63:0] exp_data;
  int          nVectors;
  int          nMiss;

  bitflip_accum_if #(.DATA_W(64), .CNT_W(32)) busA ();
  bitflip_accum_if #(.DATA_W(64), .CNT_W(8))  busB ();

  assign busA.clear     = clear;
  assign busA.in_valid  = in_valid;
  assign busA.rd_data   = rd_data;
  assign busA.exp_data  = exp_data;
  assign busA.out_ready = out_ready;
  assign busB.clear     = clear;
  assign busB.in_valid  = in_valid;
  assign busB.rd_data   = rd_data;
  assign busB.exp_data  = exp_data;
  assign busB.out_ready = out_ready;

  bitflip_accum #(.DATA_W(64), .CNT_W(32)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  bitflip_accum #(.DATA_W(64), .CNT_W(8)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nVectors++;
    assert (obs === expv) else begin
      nMiss++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] mask);
    in_valid = v;
    exp_data = PAT;
    rd_data  = PAT ^ mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nVectors  = 0;
    nMiss     = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 64'h0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("rst_out_flips", 64'(busA.out_flips), 64'd0);
    checkOutput("rst_total_flips", 64'(busA.total_flips), 64'd0);
    checkOutput("rst_total_beats", 64'(busA.total_beats), 64'd0);
    checkOutput("rst_err_beats", 64'(busA.err_beats), 64'd0);
    checkOutput("rst_sat", 64'(busA.sat), 64'd0);
    checkOutput("rst_max_flips", 64'(busA.max_flips), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_in_ready", 64'(busA.in_ready), 64'd1);

    // Three clean beats
    $display("[TB] clean beats");
    applyStimulus(1'b1, 64'h0);
    tick();
    tick();
    checkOutput("clean_out_valid", 64'(busA.out_valid), 64'd1);
    checkOutput("clean_out_flips", 64'(busA.out_flips), 64'd0);
    tick();
    applyStimulus(1'b0, 64'h0);
    tick();
    checkOutput("clean_total_beats", 64'(busA.total_beats), 64'd3);
    checkOutput("clean_err_beats", 64'(busA.err_beats), 64'd0);
    checkOutput("clean_total_flips", 64'(busA.total_flips), 64'd0);
    tick();
    checkOutput("clean_idle_valid", 64'(busA.out_valid), 64'd0);

    // Mismatches 0x1, 0xF0F0, all-ones
    $display("[TB] mismatch beats");
    applyStimulus(1'b1, 64'h1);
    tick();
    applyStimulus(1'b1, 64'hF0F0);
    tick();
    checkOutput("mm1_out_flips", 64'(busA.out_flips), 64'd1);
    applyStimulus(1'b1, ONES);
    tick();
    checkOutput("mm2_out_flips", 64'(busA.out_flips), 64'd8);
    checkOutput("mm2_total_flips", 64'(busA.total_flips), 64'd9);
    applyStimulus(1'b0, 64'h0);
    tick();
    checkOutput("mm3_out_flips", 64'(busA.out_flips), 64'd64);
    checkOutput("mm3_total_flips", 64'(busA.total_flips), 64'd73);
    checkOutput("mm3_err_beats", 64'(busA.err_beats), 64'd3);
    checkOutput("mm3_total_beats", 64'(busA.total_beats), 64'd6);
    checkOutput("mm3_max_flips", 64'(busA.max_flips), MAX_EN ? 64'd64 : 64'd0);
    tick();
    checkOutput("mm_idle_valid", 64'(busA.out_valid), 64'd0);

    // Back-pressure for five cycles with continuous offers
    $display("[TB] stall");
    out_ready = 1'b0;
    applyStimulus(1'b1, 64'h3);
    tick();
    applyStimulus(1'b1, 64'h700);
    tick();
    applyStimulus(1'b1, 64'hF000_0000_0000_0000);
    checkOutput("stall_in_ready", 64'(busA.in_ready), 64'd0);
    checkOutput("stall_out_valid", 64'(busA.out_valid), 64'd1);
    checkOutput("stall_out_flips", 64'(busA.out_flips), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_in_ready", 64'(busA.in_ready), 64'd0);
      checkOutput("stall_hold_out_flips", 64'(busA.out_flips), 64'd2);
      checkOutput("stall_hold_beats", 64'(busA.total_beats), 64'd7);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(busA.in_ready), 64'd1);
    tick();
    checkOutput("release_out_flips_p2", 64'(busA.out_flips), 64'd3);
    checkOutput("release_out_valid", 64'(busA.out_valid), 64'd1);
    applyStimulus(1'b0, 64'h0);
    tick();
    checkOutput("release_out_flips_p3", 64'(busA.out_flips), 64'd4);
    tick();
    checkOutput("release_idle_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("release_total_beats", 64'(busA.total_beats), 64'd9);
    checkOutput("release_total_flips", 64'(busA.total_flips), 64'd82);
    checkOutput("release_err_beats", 64'(busA.err_beats), 64'd6);

    // clear with one beat in S1 and another offered
    $display("[TB] clear flush");
    applyStimulus(1'b1, 64'h1F);
    tick();
    clear = 1'b1;
    applyStimulus(1'b1, 64'h3F);
    #1;
    checkOutput("clear_in_ready", 64'(busA.in_ready), 64'd0);
    tick();
    clear = 1'b0;
    applyStimulus(1'b0, 64'h0);
    checkOutput("clear_out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("clear_total_flips", 64'(busA.total_flips), 64'd0);
    checkOutput("clear_total_beats", 64'(busA.total_beats), 64'd0);
    checkOutput("clear_err_beats", 64'(busA.err_beats), 64'd0);
    checkOutput("clear_max_flips", 64'(busA.max_flips), 64'd0);
    tick();
    checkOutput("clear_flush_valid", 64'(busA.out_valid), 64'd0);
    tick();
    checkOutput("clear_flush_valid2", 64'(busA.out_valid), 64'd0);
    checkOutput("clear_flush_beats", 64'(busA.total_beats), 64'd0);

    // Five all-ones beats against the 8-bit totals
    $display("[TB] saturation");
    applyStimulus(1'b1, ONES);
    tick();
    tick();
    checkOutput("sat_r1_flipsB", 64'(busB.total_flips), 64'd64);
    tick();
    checkOutput("sat_r2_flipsB", 64'(busB.total_flips), 64'd128);
    tick();
    checkOutput("sat_r3_flipsB", 64'(busB.total_flips), 64'd192);
    checkOutput("sat_r3_satB", 64'(busB.sat), 64'd0);
    tick();
    checkOutput("sat_r4_flipsB", 64'(busB.total_flips), 64'd255);
    checkOutput("sat_r4_satB", 64'(busB.sat), 64'd1);
    applyStimulus(1'b0, 64'h0);
    tick();
    checkOutput("sat_r5_flipsB", 64'(busB.total_flips), 64'd255);
    checkOutput("sat_r5_beatsB", 64'(busB.total_beats), 64'd5);
    checkOutput("sat_r5_errB", 64'(busB.err_beats), 64'd5);
    checkOutput("sat_r5_satB", 64'(busB.sat), 64'd1);
    checkOutput("sat_r5_outB", 64'(busB.out_flips), 64'd64);
    checkOutput("sat_r5_flipsA", 64'(busA.total_flips), 64'd320);
    checkOutput("sat_r5_satA", 64'(busA.sat), 64'd0);

    // Maximum tracker with counts 3, 17, 5
    $display("[TB] max tracking");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("max_clear_satB", 64'(busB.sat), 64'd0);
    applyStimulus(1'b1, 64'h7);
    tick();
    applyStimulus(1'b1, 64'h1FFFF);
    tick();
    checkOutput("max_b1_flips", 64'(busA.out_flips), 64'd3);
    checkOutput("max_b1_max", 64'(busA.max_flips), MAX_EN ? 64'd3 : 64'd0);
    applyStimulus(1'b1, 64'h1F);
    tick();
    checkOutput("max_b2_flips", 64'(busA.out_flips), 64'd17);
    applyStimulus(1'b0, 64'h0);
    tick();
    checkOutput("max_b3_flips", 64'(busA.out_flips), 64'd5);
    checkOutput("max_b3_max", 64'(busA.max_flips), MAX_EN ? 64'd17 : 64'd0);
    checkOutput("max_b3_total", 64'(busA.total_flips), 64'd25);
    tick();

    // Asynchronous reset with a result in flight
    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, 64'hFF);
    tick();
    applyStimulus(1'b0, 64'h0);
    tick();
    checkOutput("midrst_pre_valid", 64'(busA.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("midrst_total_beats", 64'(busA.total_beats), 64'd0);
    checkOutput("midrst_total_flips", 64'(busA.total_flips), 64'd0);
    checkOutput("midrst_max_flips", 64'(busA.max_flips), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_in_ready", 64'(busA.in_ready), 64'd1);
    checkOutput("midrst_post_valid", 64'(busA.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end
endmodule
